ps2_movement_decoder: RTL and testbench
=======================================

# ps2_movement_decoder

Receives the PS/2 keyboard serial stream, assembles scan-code frames and turns Set-2 make/break codes into the 6-bit `movement` bus. That bus is consumed by the welcome-screen state control and by the in-game player control. It sits directly upstream of those blocks. It is the only place in the design that knows about PS/2 framing or scan codes.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles without a `ps2_clk` falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- `SYNC_STAGES`, default 2: synchroniser depth for `ps2_clk` and `ps2_data`. Legal range is ≥2.

Ports (clock and reset first):
- `clk`  in  1  system clock. This is the one clock; everything is in this domain.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ps2_clk`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  raw PS/2 data pin, asynchronous.
- `movement`  out  6  one-cycle press pulses. Bits: [0] up, [1] left, [2] right, [3] down, [4] confirm, [5] back.
- `keys_held`  out  6  level per bit, with the same mapping. High while the key is down.
- `frame_err`  out  1  one-cycle pulse on a bad start bit, bad stop bit, bad parity, or timeout.

## Operation
- Both pins pass through `SYNC_STAGES` flops. A falling edge of `ps2_clk` is detected from the last two synchronised samples.
- Frame receiver FSM, advanced only on detected falling edges:
  - IDLE: a start bit of 0 goes to DATA. A start bit of 1 raises `frame_err` and stays in IDLE.
  - DATA: shifts 8 bits LSB-first, then goes to PARITY.
  - PARITY: samples the parity bit, then goes to STOP.
  - STOP: a stop bit of 1 delivers the byte. A stop bit of 0 raises `frame_err` and drops the byte. Either way the FSM returns to IDLE.
- Timeout counter:
  - Clears on every falling edge and whenever the receiver is in IDLE.
  - Saturates at `TIMEOUT_CYCLES`. On reaching it outside IDLE, the receiver returns to IDLE and pulses `frame_err`.
- Code decoder, acting on each delivered byte:
  - `E0`: sets `ext`.
  - `F0`: sets `brk`.
  - Any other byte: looks up the key using `ext`, then clears both `ext` and `brk`.
- Key map:
  - Non-extended: W `1D`→0, A `1C`→1, D `23`→2, S `1B`→3, Enter `5A`→4, Esc `76`→5.
  - Extended: `E0 75`→0, `E0 6B`→1, `E0 74`→2, `E0 72`→3.
  - Unmapped codes have no effect on `movement` or `keys_held`.
- Key updates:
  - Make (`brk`=0): set the `keys_held` bit.
  - Break (`brk`=1): clear the `keys_held` bit.
- `movement[i]` pulses only on a 0→1 transition of `keys_held[i]`. Typematic repeat make codes therefore produce no further pulses.
- Two mapped keys, e.g. WASD up and arrow up, share a bit. A break from either clears the bit.

## Timing
- Reset values: all outputs 0, receiver in IDLE, `ext`=`brk`=0, counters 0.
- Latency:
  - Let T be the cycle the stop-bit falling edge is detected.
  - The byte is delivered at T+1.
  - `keys_held` and `movement` update at T+2.
  - `movement` is high for exactly that one cycle.
- Edge-detect delay: `SYNC_STAGES`+1 cycles from the pin.
- `frame_err` is registered and asserts the cycle after the offending edge or timeout.
- Reset asserted mid-frame discards the partial byte and the prefix flags. After release, decoding restarts with the next start bit.
- A prefix followed by timeout: the prefix flags are kept. Only the partial frame is dropped.

## Configuration
- `PS2_PARITY_CHECK_EN` defined: in STOP, the byte is delivered only if the 8 data bits plus the parity bit have odd parity. Otherwise the byte is dropped and `frame_err` pulses.
- Not defined: the parity bit is sampled and ignored. Delivery depends only on the start and stop bits.

## Structure
- Shared package `ps2_pkg`:
  - scan-code constants (`SC_EXT`, `SC_BRK`, key codes);
  - movement bit indices (`MV_UP`, `MV_LEFT`, `MV_RIGHT`, `MV_DOWN`, `MV_CONFIRM`, `MV_BACK`);
  - receiver state encoding.
- The game and welcome blocks index `movement` through this package.
- One sub-module, `ps2_frame_rx`, contains synchroniser, edge detect, frame FSM, timeout and parity. Its outputs are `byte_valid`, `byte_data`, `err`.
- The decoder and key map live in the top module.

## Test plan
- Frame `1D`, then later `F0 1D`: `keys_held[0]` and `movement[0]` go high at T+2 of the first frame, with `movement[0]` high for one cycle. `keys_held[0]` returns to 0 after the break.
- Frame `1D` sent three times as typematic repeat, then `F0 1D`: exactly one `movement[0]` pulse in total.
- Extended sequence `E0 72`, then `E0 F0 72`: `keys_held[3]` goes 1 then 0. Sending plain `72` alone leaves all outputs at 0.
- Frame `5A` with wrong parity:
  - with `PS2_PARITY_CHECK_EN`: one `frame_err` pulse, `keys_held` unchanged;
  - without it: `keys_held[4]`=1.
- Send 5 bits, then hold `ps2_clk` high for `TIMEOUT_CYCLES`: one `frame_err` pulse. A following valid `76` frame sets `keys_held[5]`.
- Assert `rst_n`=0 mid-frame with `keys_held`=6'b000001: outputs are 0 during reset. After release, a valid `1C` frame produces `movement[1]` only.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: scan codes, movement bit indices, receiver states
// and the Set-2 key map shared by the PS/2 decoder and its consumers.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  localparam int MV_UP      = 0;
  localparam int MV_LEFT    = 1;
  localparam int MV_RIGHT   = 2;
  localparam int MV_DOWN    = 3;
  localparam int MV_CONFIRM = 4;
  localparam int MV_BACK    = 5;
  localparam int MV_W       = 6;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_hit_t;

  function automatic key_hit_t key_lookup(
    input logic       ext,
    input logic [7:0] code
  );
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = 3'd0;
    if (!ext) begin
      case (code)
        SC_W:     r.idx = 3'(MV_UP);
        SC_A:     r.idx = 3'(MV_LEFT);
        SC_D:     r.idx = 3'(MV_RIGHT);
        SC_S:     r.idx = 3'(MV_DOWN);
        SC_ENTER: r.idx = 3'(MV_CONFIRM);
        SC_ESC:   r.idx = 3'(MV_BACK);
        default:  r.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_UP:    r.idx = 3'(MV_UP);
        SC_LEFT:  r.idx = 3'(MV_LEFT);
        SC_RIGHT: r.idx = 3'(MV_RIGHT);
        SC_DOWN:  r.idx = 3'(MV_DOWN);
        default:  r.hit = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: pin synchroniser, falling-edge detect, 11-bit frame FSM
// and inactivity timeout. Odd-parity check enabled by PS2_PARITY_CHECK_EN.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic                   fall;
  logic                   bit_in;

  // Idle-high reset so release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_in = dat_sync_q[SYNC_STAGES-1];

  rx_state_e   state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_cnt_q;
  logic        par_q;
  logic        byte_valid_q;
  logic [7:0]  byte_q;
  logic        err_q;
  logic [TW-1:0] to_q;
  logic [TW-1:0] to_d;
  logic        timeout;
  logic        stop_ok;

  always_comb begin
    to_d = to_q;
    if (fall || state_q == RX_IDLE) begin
      to_d = '0;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + 1'b1;
    end
  end

  assign timeout = (state_q != RX_IDLE) && (to_q == TO_MAX) && !fall;

  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    stop_ok = bit_in & (^{shift_q, par_q});
`else
    stop_ok = bit_in;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      err_q        <= 1'b0;
      if (timeout) begin
        state_q <= RX_IDLE;
        err_q   <= 1'b1;
      end else if (fall) begin
        unique case (state_q)
          RX_IDLE: begin
            if (!bit_in) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
          RX_DATA: begin
            shift_q   <= {bit_in, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            par_q   <= bit_in;
            state_q <= RX_STOP;
          end
          RX_STOP: begin
            state_q <= RX_IDLE;
            if (stop_ok) begin
              byte_valid_q <= 1'b1;
              byte_q       <= shift_q;
            end else begin
              err_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_q;
  assign err        = err_q;

endmodule

// File: rtl/ps2_movement_decoder.sv
// ps2_movement_decoder: Set-2 make/break decoding into held-key levels
// and press pulses. Build option: PS2_PARITY_CHECK_EN (in ps2_frame_rx).
module ps2_movement_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  output logic [MV_W-1:0] movement,
  output logic [MV_W-1:0] keys_held,
  output logic            frame_err
);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_err;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .err        (rx_err)
  );

  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [MV_W-1:0] keys_q, keys_d;
  logic [MV_W-1:0] mv_q, mv_d;
  key_hit_t        hit;

  assign hit = key_lookup(ext_q, byte_data);

  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    keys_d = keys_q;
    if (byte_valid) begin
      unique case (1'b1)
        byte_data == SC_EXT: ext_d = 1'b1;
        byte_data == SC_BRK: brk_d = 1'b1;
        default: begin
          if (hit.hit) keys_d[hit.idx] = ~brk_q;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
    // Only a fresh press pulses; typematic repeats leave the bit set.
    mv_d = keys_d & ~keys_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      keys_q <= '0;
      mv_q   <= '0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      keys_q <= keys_d;
      mv_q   <= mv_d;
    end
  end

  assign movement  = mv_q;
  assign keys_held = keys_q;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_movement_decoder.sv
// tb_ps2_movement_decoder: directed PS/2 frames with hand-computed
// expected key levels, press-pulse counts and error counts.
module tb_ps2_movement_decoder;

  localparam int TO   = 100;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [5:0] movement;
  logic [5:0] keys_held;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_movement_decoder #(
    .TIMEOUT_CYCLES (TO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .movement  (movement),
    .keys_held (keys_held),
    .frame_err (frame_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mv_hi [6] = '{default: 0};
  int err_hi = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) mv_hi[i] += int'(movement[i]);
    err_hi += int'(frame_err);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic badpar);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ badpar);
    send_bit(1'b1);
    repeat (10) @(negedge clk);
  endtask

  int b0, b1, b3, e0, others;
  logic [7:0] w_code;

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_movement", 32'(movement), 32'h0);
    chk("rst_keys", 32'(keys_held), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // W make with exact stop-bit latency
    w_code = 8'h1D;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(w_code[i]);
    send_bit(~^w_code);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    chk("lat_keys_t1", 32'(keys_held), 32'h0);
    @(negedge clk);
    chk("lat_keys_t2", 32'(keys_held), 32'h01);
    chk("lat_mv_t2", 32'(movement), 32'h01);
    @(negedge clk);
    chk("lat_mv_t3", 32'(movement), 32'h0);
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    chk("w_break_keys", 32'(keys_held), 32'h0);
    chk("w_pulse_cnt", 32'(mv_hi[0]), 32'd1);

    // typematic repeat
    b0 = mv_hi[0];
    repeat (3) send_frame(8'h1D, 1'b0);
    chk("rep_keys", 32'(keys_held), 32'h01);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    chk("rep_pulses", 32'(mv_hi[0] - b0), 32'd1);
    chk("rep_break", 32'(keys_held), 32'h0);

    // extended down arrow
    b3 = mv_hi[3];
    send_frame(8'hE0, 1'b0);
    send_frame(8'h72, 1'b0);
    chk("ext_make", 32'(keys_held), 32'h08);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h72, 1'b0);
    chk("ext_break", 32'(keys_held), 32'h0);
    send_frame(8'h72, 1'b0);
    chk("plain72_keys", 32'(keys_held), 32'h0);
    chk("plain72_pulses", 32'(mv_hi[3] - b3), 32'd1);

    // Enter with wrong parity
    e0 = err_hi;
    send_frame(8'h5A, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_err", 32'(err_hi - e0), 32'd1);
    chk("par_keys", 32'(keys_held), 32'h0);
`else
    chk("par_err", 32'(err_hi - e0), 32'd0);
    chk("par_keys", 32'(keys_held), 32'h10);
`endif
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    chk("par_clear", 32'(keys_held), 32'h0);

    // partial frame then timeout
    e0 = err_hi;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (TO + 50) @(negedge clk);
    chk("to_err", 32'(err_hi - e0), 32'd1);
    send_frame(8'h76, 1'b0);
    chk("to_esc_keys", 32'(keys_held), 32'h20);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h76, 1'b0);

    // reset mid-frame
    send_frame(8'h1D, 1'b0);
    chk("pre_rst_keys", 32'(keys_held), 32'h01);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_keys", 32'(keys_held), 32'h0);
    chk("mid_rst_mv", 32'(movement), 32'h0);
    chk("mid_rst_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    b0 = mv_hi[0];
    b1 = mv_hi[1];
    others = mv_hi[0] + mv_hi[2] + mv_hi[3] + mv_hi[4] + mv_hi[5];
    send_frame(8'h1C, 1'b0);
    chk("post_rst_mv1", 32'(mv_hi[1] - b1), 32'd1);
    chk("post_rst_other",
        32'(mv_hi[0] + mv_hi[2] + mv_hi[3] + mv_hi[4] + mv_hi[5] - others),
        32'd0);
    chk("post_rst_keys", 32'(keys_held), 32'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
